fir_param: RTL and testbench
============================

Name: fir_param

Overview:
- Parametrised successor to the fixed 8-bit FIR1 direct-form filter.
- Signed direct-form FIR with a run-time loadable coefficient bank, an input valid qualifier and a 2-stage registered pipeline.
- Also provides a synchronous flush and scaled, range-limited output.
- Sits between the sample source and downstream DSP in the filter chain; one sample per clock maximum.

Parameters:
- TAPS, 4, number of taps / delay-line length (>=2).
- DATA_W, 8, signed input sample width.
- COEF_W, 8, signed coefficient width.
- OUT_W, 8, signed output width.
- SHIFT, 0, arithmetic right shift applied to the accumulator before output range-limiting (0..ACC_W-1).
- Derived: ACC_W = DATA_W + COEF_W + clog2(TAPS); AW = clog2(TAPS).

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- i_valid, in, 1, i_x carries a new sample this cycle.
- i_x, in, DATA_W, signed input sample.
- i_clear, in, 1, synchronous flush of the delay line and pipeline.
- coef_we, in, 1, coefficient write strobe.
- coef_addr, in, AW, tap index to write.
- coef_wdata, in, COEF_W, signed coefficient value.
- o_valid, out, 1, o_y holds a new result this cycle.
- o_y, out, OUT_W, signed filtered output.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Delay line x[0..TAPS-1] = 0.
  - Stage-1 accumulator = 0; valid pipe v1 = 0, o_valid = 0, o_y = 0.
  - Coefficients c[0] = 1, c[1..TAPS-1] = 0, i.e. pass-through, so default behaviour matches FIR1 with unit gain.
- Capture: on a rising edge with i_valid=1 and i_clear=0:
  - x[0] <= i_x; x[k] <= x[k-1] for k = 1..TAPS-1; v1 <= 1.
  - With i_valid=0 the delay line holds and v1 <= 0.
- Stage 1, the edge after capture: acc <= sum over k of c[k]*x[k], full precision, signed, ACC_W bits; v1 is forwarded.
- Stage 2, the next edge: o_y <= limit(acc >>> SHIFT); o_valid <= v1.
- Latency: for a sample captured at edge E0, the result appears after edge E2 (2 clocks). Back-to-back valid samples give one result per clock.
- o_y holds its last value while o_valid=0. o_valid is a single-cycle pulse per sample.
- Range-limiting is set by the optional feature below.
- Coefficient write: on an edge with coef_we=1, c[coef_addr] <= coef_wdata.
  - coef_addr >= TAPS: write ignored.
  - The write is visible to a stage-1 computation occurring at the following edge or later.
  - A write coinciding with a stage-1 edge is not seen by that computation; stage 1 uses the pre-write value.
- i_clear=1 at an edge:
  - Delay line, acc, v1 and o_valid are cleared to 0; o_y holds its last value.
  - i_clear dominates i_valid: a simultaneous sample is discarded.
  - Coefficients are unaffected.
  - The first post-clear result therefore sees zeros in all older taps.
- Reset mid-operation: all in-flight results are discarded immediately and coefficients return to their reset values. No o_valid pulse is produced for pre-reset samples.

Optional Feature:
- Macro FIR_PARAM_SAT_EN.
- Defined: limit() saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: limit() truncates to the low OUT_W bits (two's-complement wrap), matching FIR1 arithmetic.

Test Plan:
- Default config (reset coefficients, SHIFT=0), samples 1,-6,10,2,-4 on consecutive cycles with i_valid=1 -> o_y = 1,-6,10,2,-4 with o_valid high, each 2 clocks after its capture edge.
- Load c = {1,1,1,1}, then the same sequence -> o_y = 1,-5,5,7,2 (running 4-tap sums).
- Load c = {127,127,127,127}, single sample 100 followed by zeros -> o_y = 127 ×4 then 0 with FIR_PARAM_SAT_EN; o_y = -100 (12700 wrapped to 8 bits) ×4 then 0 without.
- Sparse input, i_valid pattern 1,0,0,1 with samples 3,X,X,5 and c = {1,1,0,0} -> exactly two o_valid pulses, o_y = 3 then 8; o_y holds between pulses.
- i_clear asserted together with i_valid (sample 9) after samples 1,2 with c = {1,1,1,1} -> 9 is discarded, no o_valid for in-flight samples; next sample 4 -> o_y = 4.
- rst_n pulsed low while 2 samples are in flight -> outputs go to 0 asynchronously, no stale o_valid; coefficients revert to pass-through, verified by input 7 -> o_y = 7.

Source files
------------

// File: rtl/fir_param.sv
// fir_param: signed direct-form FIR filter with a run-time loadable coefficient bank.
//
// Pipeline: capture edge (delay line shifts) -> stage 1 (full-precision sum of products)
// -> stage 2 (arithmetic shift, range-limit, registered output). A sample captured at
// edge E0 appears on o_y/o_valid after edge E2; back-to-back samples give one result
// per clock.
//
// Ports:
//   clk         in   1            system clock, rising edge
//   rst_n       in   1            asynchronous active-low reset
//   i_valid     in   1            i_x carries a new sample this cycle
//   i_x         in   DATA_W       signed input sample
//   i_clear     in   1            synchronous flush of delay line and pipeline
//   coef_we     in   1            coefficient write strobe
//   coef_addr   in   AW           tap index to write (>= TAPS is ignored)
//   coef_wdata  in   COEF_W       signed coefficient value
//   o_valid     out  1            single-cycle pulse: o_y holds a new result
//   o_y         out  OUT_W        signed filtered output (holds between pulses)
//
// Build option:
//   FIR_PARAM_SAT_EN  defined   -> output saturates to the OUT_W signed range
//                     undefined -> output wraps to the low OUT_W bits
//
// Reset coefficients are c[0] = 1, others 0 (unit-gain pass-through).
// OUT_W is expected to be no wider than ACC_W.

`timescale 1ns / 1ps

module fir_param #(
    parameter int unsigned TAPS   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_valid,
    input  logic signed [DATA_W-1:0]   i_x,
    input  logic                       i_clear,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    output logic                       o_valid,
    output logic signed [OUT_W-1:0]    o_y
);

    localparam int unsigned AW    = $clog2(TAPS);
    localparam int unsigned ACC_W = DATA_W + COEF_W + AW;

    // TAPS <= 2**AW, so it always fits in AW+1 bits.
    localparam logic [AW:0] TapsW = (AW + 1)'(TAPS);

    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [COEF_W-1:0] c_q [TAPS];
    logic signed [ACC_W-1:0]  acc_q;
    logic                     v1_q;   // delay line holds a freshly captured sample
    logic                     v2_q;   // acc_q holds a result for that sample

    logic signed [ACC_W-1:0]  sum_d;
    logic signed [OUT_W-1:0]  y_d;
    logic                     coef_addr_ok;

    assign coef_addr_ok = ({1'b0, coef_addr} < TapsW);

    // Operands are sign-extended to ACC_W first so every product and the running sum
    // are computed at full precision.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < int'(TAPS); k++) begin
            sum_d = sum_d + ACC_W'(x_q[k]) * ACC_W'(c_q[k]);
        end
    end

`ifdef FIR_PARAM_SAT_EN
    localparam int unsigned ExtW = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    logic signed [ExtW-1:0] sh_ext;

    // In range when every bit from the output sign bit upward agrees.
    always_comb begin
        sh_ext = ExtW'(acc_q >>> SHIFT);
        if (sh_ext[ExtW-1:OUT_W-1] == '0 || sh_ext[ExtW-1:OUT_W-1] == '1) begin
            y_d = sh_ext[OUT_W-1:0];
        end else if (sh_ext[ExtW-1]) begin
            y_d = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            y_d = {1'b0, {(OUT_W - 1){1'b1}}};
        end
    end
`else
    always_comb begin
        y_d = OUT_W'(acc_q >>> SHIFT);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                x_q[k] <= '0;
                c_q[k] <= (k == 0) ? COEF_W'(1) : '0;
            end
            acc_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            o_valid <= 1'b0;
            o_y     <= '0;
        end else begin
            if (i_clear) begin
                // o_y deliberately keeps its last value.
                for (int k = 0; k < int'(TAPS); k++) begin
                    x_q[k] <= '0;
                end
                acc_q   <= '0;
                v1_q    <= 1'b0;
                v2_q    <= 1'b0;
                o_valid <= 1'b0;
            end else begin
                if (i_valid) begin
                    x_q[0] <= i_x;
                    for (int k = 1; k < int'(TAPS); k++) begin
                        x_q[k] <= x_q[k-1];
                    end
                end
                v1_q <= i_valid;
                if (v1_q) begin
                    acc_q <= sum_d;
                end
                v2_q    <= v1_q;
                o_valid <= v2_q;
                if (v2_q) begin
                    o_y <= y_d;
                end
            end
            // Stage 1 at this same edge reads the pre-write coefficient.
            if (coef_we && coef_addr_ok) begin
                c_q[coef_addr] <= coef_wdata;
            end
        end
    end

endmodule

// File: tb/tb_fir_param.sv
`timescale 1ns / 1ps

module tb_fir_param;

    localparam int TAPS   = 4;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 0;
    localparam int AW     = $clog2(TAPS);

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     i_valid;
    logic signed [DATA_W-1:0] i_x;
    logic                     i_clear;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     o_valid;
    logic signed [OUT_W-1:0]  o_y;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: sample history, coefficient bank, and a list of expected
    // results ordered by the cycle on which they are due.
    int hist [TAPS];
    int mc   [TAPS];
    int pend_v [$];
    int pend_y [$];
    int last_y;

    fir_param #(
        .TAPS  (TAPS),
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .i_x       (i_x),
        .i_clear   (i_clear),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .o_valid   (o_valid),
        .o_y       (o_y)
    );

    always #5 clk = ~clk;

    function automatic int limit(input int a);
        int s;
`ifdef FIR_PARAM_SAT_EN
        s = a >>> SHIFT;
        if (s > (2 ** (OUT_W - 1)) - 1) return (2 ** (OUT_W - 1)) - 1;
        if (s < -(2 ** (OUT_W - 1))) return -(2 ** (OUT_W - 1));
        return s;
`else
        logic signed [OUT_W-1:0] w;
        s = a >>> SHIFT;
        w = OUT_W'(s);
        return int'(w);
`endif
    endfunction

    function automatic int model_sum();
        int s = 0;
        for (int k = 0; k < TAPS; k++) s += mc[k] * hist[k];
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            hist[k] = 0;
            mc[k]   = (k == 0) ? 1 : 0;
        end
        pend_v = '{0, 0};
        pend_y = '{0, 0};
        last_y = 0;
    endtask

    // Drive one clock of stimulus, advance the model, return what must be seen now.
    task automatic step(input logic v, input int x, input logic clr, input logic we,
                        input int addr, input int wd, output logic ev, output int ey);
        int due_y;
        i_valid    = v;
        i_x        = DATA_W'(x);
        i_clear    = clr;
        coef_we    = we;
        coef_addr  = AW'(addr);
        coef_wdata = COEF_W'(wd);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        coef_we = 1'b0;
        if (we && addr < TAPS) mc[addr] = wd;
        if (clr) begin
            for (int k = 0; k < TAPS; k++) hist[k] = 0;
            foreach (pend_v[i]) pend_v[i] = 0;
        end else if (v) begin
            for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = x;
        end
        pend_v.push_back((v && !clr) ? 1 : 0);
        pend_y.push_back((v && !clr) ? limit(model_sum()) : 0);
        ev    = (pend_v.pop_front() != 0);
        due_y = pend_y.pop_front();
        if (ev) last_y = due_y;
        ey = last_y;
    endtask

    task automatic load_coefs(input int cv [TAPS]);
        logic ev;
        int   ey;
        for (int k = 0; k < TAPS; k++) step(1'b0, 0, 1'b0, 1'b1, k, cv[k], ev, ey);
    endtask

    task automatic do_reset_assert();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
    endtask

    task automatic do_reset_release();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic ev;
        int   ey;
        i_valid = 0; i_x = '0; i_clear = 0; coef_we = 0; coef_addr = '0; coef_wdata = '0;
        do_reset_assert();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_o_valid got %b want 0", o_valid);
        end
        n_checks++;
        if (o_y !== '0) begin
            n_fail++; $display("FAIL reset_o_y got %0d want 0", o_y);
        end
        do_reset_release();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 1'b0, 1'b0, 0, 0, ev, ey);
            n_checks++;
            if (o_valid !== ev) begin
                n_fail++; $display("FAIL reset_idle_v[%0d] got %b want %b", i, o_valid, ev);
            end
            n_checks++;
            if (o_y !== OUT_W'(ey)) begin
                n_fail++; $display("FAIL reset_idle_y[%0d] got %0d want %0d", i, o_y, ey);
            end
        end
    endtask

    task automatic test_passthrough();
        int   xs [5] = '{1, -6, 10, 2, -4};
        logic ev;
        int   ey;
        for (int i = 0; i < 7; i++) begin
            step(i < 5, (i < 5) ? xs[i] : 0, 1'b0, 1'b0, 0, 0, ev, ey);
            n_checks++;
            if (o_valid !== ev) begin
                n_fail++; $display("FAIL pass_v[%0d] got %b want %b", i, o_valid, ev);
            end
            n_checks++;
            if (o_y !== OUT_W'(ey)) begin
                n_fail++; $display("FAIL pass_y[%0d] got %0d want %0d", i, o_y, ey);
            end
        end
    endtask

    task automatic test_sum4();
        int   xs [5] = '{1, -6, 10, 2, -4};
        int   cv [TAPS] = '{1, 1, 1, 1};
        logic ev;
        int   ey;
        step(1'b0, 0, 1'b1, 1'b0, 0, 0, ev, ey);
        load_coefs(cv);
        for (int i = 0; i < 7; i++) begin
            step(i < 5, (i < 5) ? xs[i] : 0, 1'b0, 1'b0, 0, 0, ev, ey);
            n_checks++;
            if (o_valid !== ev) begin
                n_fail++; $display("FAIL sum4_v[%0d] got %b want %b", i, o_valid, ev);
            end
            n_checks++;
            if (o_y !== OUT_W'(ey)) begin
                n_fail++; $display("FAIL sum4_y[%0d] got %0d want %0d", i, o_y, ey);
            end
        end
    endtask

    task automatic test_saturation();
        int   cv [TAPS] = '{127, 127, 127, 127};
        logic ev;
        int   ey;
        step(1'b0, 0, 1'b1, 1'b0, 0, 0, ev, ey);
        load_coefs(cv);
        for (int i = 0; i < 7; i++) begin
            step(i < 5, (i == 0) ? 100 : 0, 1'b0, 1'b0, 0, 0, ev, ey);
            n_checks++;
            if (o_valid !== ev) begin
                n_fail++; $display("FAIL sat_v[%0d] got %b want %b", i, o_valid, ev);
            end
            n_checks++;
            if (o_y !== OUT_W'(ey)) begin
                n_fail++; $display("FAIL sat_y[%0d] got %0d want %0d", i, o_y, ey);
            end
        end
    endtask

    task automatic test_sparse();
        int   cv [TAPS] = '{1, 1, 0, 0};
        int   xs [7]    = '{3, 77, -50, 5, 0, 0, 0};
        int   vs [7]    = '{1, 0, 0, 1, 0, 0, 0};
        logic ev;
        int   ey;
        step(1'b0, 0, 1'b1, 1'b0, 0, 0, ev, ey);
        load_coefs(cv);
        for (int i = 0; i < 7; i++) begin
            step(vs[i] != 0, xs[i], 1'b0, 1'b0, 0, 0, ev, ey);
            n_checks++;
            if (o_valid !== ev) begin
                n_fail++; $display("FAIL sparse_v[%0d] got %b want %b", i, o_valid, ev);
            end
            n_checks++;
            if (o_y !== OUT_W'(ey)) begin
                n_fail++; $display("FAIL sparse_y[%0d] got %0d want %0d", i, o_y, ey);
            end
        end
    endtask

    task automatic test_clear();
        int   cv [TAPS] = '{1, 1, 1, 1};
        int   xs [7]    = '{1, 2, 9, 4, 0, 0, 0};
        int   vs [7]    = '{1, 1, 1, 1, 0, 0, 0};
        int   cs [7]    = '{0, 0, 1, 0, 0, 0, 0};
        logic ev;
        int   ey;
        load_coefs(cv);
        for (int i = 0; i < 7; i++) begin
            step(vs[i] != 0, xs[i], cs[i] != 0, 1'b0, 0, 0, ev, ey);
            n_checks++;
            if (o_valid !== ev) begin
                n_fail++; $display("FAIL clear_v[%0d] got %b want %b", i, o_valid, ev);
            end
            n_checks++;
            if (o_y !== OUT_W'(ey)) begin
                n_fail++; $display("FAIL clear_y[%0d] got %0d want %0d", i, o_y, ey);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic ev;
        int   ey;
        step(1'b1, 11, 1'b0, 1'b0, 0, 0, ev, ey);
        step(1'b1, 12, 1'b0, 1'b0, 0, 0, ev, ey);
        do_reset_assert();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_o_valid got %b want 0", o_valid);
        end
        n_checks++;
        if (o_y !== '0) begin
            n_fail++; $display("FAIL midrst_o_y got %0d want 0", o_y);
        end
        do_reset_release();
        for (int i = 0; i < 4; i++) begin
            step(i == 0, (i == 0) ? 7 : 0, 1'b0, 1'b0, 0, 0, ev, ey);
            n_checks++;
            if (o_valid !== ev) begin
                n_fail++; $display("FAIL midrst_v[%0d] got %b want %b", i, o_valid, ev);
            end
            n_checks++;
            if (o_y !== OUT_W'(ey)) begin
                n_fail++; $display("FAIL midrst_y[%0d] got %0d want %0d", i, o_y, ey);
            end
        end
    endtask

    // Random samples, valid gaps, occasional flushes and coefficient writes in flight.
    task automatic test_random();
        logic ev;
        int   ey;
        logic v, clr, we;
        int   x, addr, wd;
        for (int i = 0; i < 120; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            x    = int'($urandom_range(0, 255)) - 128;
            clr  = ($urandom_range(0, 19) == 0);
            we   = ($urandom_range(0, 4) == 0);
            addr = int'($urandom_range(0, TAPS - 1));
            wd   = int'($urandom_range(0, 255)) - 128;
            step(v, x, clr, we, addr, wd, ev, ey);
            n_checks++;
            if (o_valid !== ev) begin
                n_fail++; $display("FAIL rand_v[%0d] got %b want %b", i, o_valid, ev);
            end
            n_checks++;
            if (o_y !== OUT_W'(ey)) begin
                n_fail++; $display("FAIL rand_y[%0d] got %0d want %0d", i, o_y, ey);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_passthrough();
        test_sum4();
        test_saturation();
        test_sparse();
        test_clear();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
